// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: register word indices, TCTL layout and
// the read value returned for unmapped offsets.
package mmio_bridge_pkg;

  // 32-byte region; addr[4:1] selects the 16-bit register slot.
  localparam int unsigned RegionBits = 5;

  localparam logic [3:0] IdxKey   = 4'h0;
  localparam logic [3:0] IdxSw    = 4'h1;
  localparam logic [3:0] IdxKie   = 4'h2;
  localparam logic [3:0] IdxKedge = 4'h3;
  localparam logic [3:0] IdxHex   = 4'h4;
  localparam logic [3:0] IdxLedr  = 4'h5;
  localparam logic [3:0] IdxLedg  = 4'h6;
  localparam logic [3:0] IdxTlim  = 4'h7;
  localparam logic [3:0] IdxTcnt  = 4'h8;
  localparam logic [3:0] IdxTctl  = 4'h9;

  localparam int unsigned TctlEn  = 0;
  localparam int unsigned TctlIe  = 1;
  localparam int unsigned TctlRdy = 2;

  localparam logic [15:0] ReadDefault = 16'hDEAD;

  typedef struct packed {
    logic rdy;
    logic ie;
    logic en;
  } tctl_t;

endpackage

// File: rtl/mmio_bridge_sync_bits.sv
// Per-bit flop chain bringing asynchronous board inputs into the clk domain.
// Reset loads INIT so idle inputs do not look like transitions after reset.
module mmio_bridge_sync_bits #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2,
  parameter logic [W-1:0] INIT  = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= INIT;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mmio_bridge.sv
// Relocatable MMIO register bank: synchronised KEY/SW inputs, sticky KEY press capture,
// HEX/LED outputs, an interval timer and a registered interrupt request.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned      DBITS    = 16,
  parameter int unsigned      ABITS    = 16,
  parameter logic [ABITS-1:0] BASE     = 'hFFE0,
  parameter int unsigned      NKEYS    = 4,
  parameter int unsigned      NSW      = 10,
  parameter int unsigned      NLEDR    = 10,
  parameter int unsigned      NLEDG    = 8,
  parameter int unsigned      NHEX     = 4,
  parameter int unsigned      SYNC     = 2,
  parameter int unsigned      PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ABITS-1:0]  addr,
  input  logic [DBITS-1:0]  wdata,
  input  logic              we,
  output logic [DBITS-1:0]  rdata,
  output logic              hit,
  output logic              irq,
  input  logic [NKEYS-1:0]  key_in,
  input  logic [NSW-1:0]    sw_in,
  output logic [4*NHEX-1:0] hex_out,
  output logic [NLEDR-1:0]  ledr,
  output logic [NLEDG-1:0]  ledg
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PreLast = PW'(PRESCALE - 1);

  logic [NKEYS-1:0]  key_s, key_prev_q, key_press, kedge_clr;
  logic [NKEYS-1:0]  kie_q, kie_d, kedge_q, kedge_d;
  logic [NSW-1:0]    sw_s;
  logic [4*NHEX-1:0] hex_q, hex_d;
  logic [NLEDR-1:0]  ledr_q, ledr_d;
  logic [NLEDG-1:0]  ledg_q, ledg_d;
  logic [DBITS-1:0]  tlim_q, tlim_d, tcnt_q, tcnt_d;
  tctl_t             tctl_q, tctl_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic              irq_q, irq_d;
  logic [3:0]        idx;
  logic              wr_en, tick, tmatch;
  logic              unused_addr0;

  mmio_bridge_sync_bits #(
    .W      (NKEYS),
    .STAGES (SYNC),
    .INIT   ({NKEYS{1'b1}})
  ) u_key_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (key_in),
    .q_o    (key_s)
  );

  mmio_bridge_sync_bits #(
    .W      (NSW),
    .STAGES (SYNC),
    .INIT   ('0)
  ) u_sw_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sw_in),
    .q_o    (sw_s)
  );

  assign hit          = addr[ABITS-1:RegionBits] == BASE[ABITS-1:RegionBits];
  assign idx          = addr[RegionBits-1:1];
  assign unused_addr0 = addr[0];
  assign wr_en        = we & hit;

  // KEY is active-low, so a press is a synced 1->0 transition.
  assign key_press = key_prev_q & ~key_s;
  assign kedge_clr = (wr_en && idx == IdxKedge) ? wdata[NKEYS-1:0] : '0;
  assign tick      = tctl_q.en && (pre_q == PreLast);
  assign tmatch    = tcnt_q == tlim_q;

  always_comb begin
    kie_d   = kie_q;
    hex_d   = hex_q;
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    tlim_d  = tlim_q;
    tcnt_d  = tcnt_q;
    tctl_d  = tctl_q;
    pre_d   = '0;
    kedge_d = (kedge_q & ~kedge_clr) | key_press;

    if (tctl_q.en && !tick) pre_d = pre_q + PW'(1);
    if (tick) tcnt_d = tmatch ? '0 : tcnt_q + DBITS'(1);

    // Bus writes are applied after the timer update so a CPU TCNT write wins over a tick.
    if (wr_en) begin
      case (idx)
        IdxKie:  kie_d  = wdata[NKEYS-1:0];
        IdxHex:  hex_d  = wdata[4*NHEX-1:0];
        IdxLedr: ledr_d = wdata[NLEDR-1:0];
        IdxLedg: ledg_d = wdata[NLEDG-1:0];
        IdxTlim: tlim_d = wdata;
        IdxTcnt: tcnt_d = wdata;
        IdxTctl: begin
          tctl_d.en = wdata[TctlEn];
          tctl_d.ie = wdata[TctlIe];
          if (wdata[TctlRdy]) tctl_d.rdy = 1'b0;
        end
        default: ;
      endcase
    end

    if (tick && tmatch) tctl_d.rdy = 1'b1;

    irq_d = (|(kedge_q & kie_q)) | (tctl_q.rdy & tctl_q.ie);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_q <= '1;
      kie_q      <= '0;
      kedge_q    <= '0;
      hex_q      <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      tlim_q     <= '0;
      tcnt_q     <= '0;
      tctl_q     <= '0;
      pre_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      key_prev_q <= key_s;
      kie_q      <= kie_d;
      kedge_q    <= kedge_d;
      hex_q      <= hex_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      tlim_q     <= tlim_d;
      tcnt_q     <= tcnt_d;
      tctl_q     <= tctl_d;
      pre_q      <= pre_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rdata = DBITS'(ReadDefault);
    case (idx)
      IdxKey:   rdata = DBITS'(key_s);
      IdxSw:    rdata = DBITS'(sw_s);
      IdxKie:   rdata = DBITS'(kie_q);
      IdxKedge: rdata = DBITS'(kedge_q);
      IdxHex:   rdata = DBITS'(hex_q);
      IdxLedr:  rdata = DBITS'(ledr_q);
      IdxLedg:  rdata = DBITS'(ledg_q);
      IdxTlim:  rdata = tlim_q;
      IdxTcnt:  rdata = tcnt_q;
      IdxTctl:  rdata = DBITS'(tctl_q);
      default:  ;
    endcase
  end

  assign hex_out = hex_q;
  assign ledr    = ledr_q;
  assign ledg    = ledg_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: register table, randomized register/SW traffic against a
// simple model, and hand-timed KEY edge, timer and reset sequences.
module tb_mmio_bridge;

  localparam int unsigned SY = 2;
  localparam int unsigned PS = 4;
  localparam logic [15:0] BASE = 16'hFFE0;

  logic        clk, rst_n, we, hit, irq;
  logic [15:0] addr, wdata, rdata, hex_out;
  logic [3:0]  key_in;
  logic [9:0]  sw_in, ledr;
  logic [7:0]  ledg;

  mmio_bridge #(
    .DBITS    (16),
    .ABITS    (16),
    .BASE     (BASE),
    .NKEYS    (4),
    .NSW      (10),
    .NLEDR    (10),
    .NLEDG    (8),
    .NHEX     (4),
    .SYNC     (SY),
    .PRESCALE (PS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .hit     (hit),
    .irq     (irq),
    .key_in  (key_in),
    .sw_in   (sw_in),
    .hex_out (hex_out),
    .ledr    (ledr),
    .ledg    (ledg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  off;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] off, input logic [15:0] d);
    addr  = BASE + 16'(off);
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  // Samples well before the next rising edge; callers keep read bursts short.
  task automatic rd(input string name, input logic [4:0] off, input logic [15:0] exp);
    addr = BASE + 16'(off);
    #1;
    check(name, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  offs[6];
    logic [15:0] masks[6];
    logic [15:0] m[6];
    logic [15:0] sw_old, sw_new, d;
    int          sw_cyc, r, t0;

    rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0; key_in = 4'hF; sw_in = '0;
    #3;
    check("irq_in_reset", irq, 0);
    #9 rst_n = 1'b1;
    step();

    // Reset values and decode boundaries.
    rd("rst_key", 5'h00, 16'h000F);
    rd("rst_sw", 5'h02, 16'h0000);
    rd("rst_hex", 5'h08, 16'h0000);
    rd("rst_off14", 5'h14, 16'hDEAD);
    addr = 16'hFFDE; #1 check("hit_below", hit, 0);
    addr = 16'hFFE0; #1 check("hit_base", hit, 1);
    addr = 16'hFFFF; #1 check("hit_top", hit, 1);
    step();
    addr = 16'h0000; #1 check("hit_zero", hit, 0);
    check("rst_irq", irq, 0);

    tbl[0]  = '{5'h08, 16'h1234, 16'h1234};
    tbl[1]  = '{5'h0A, 16'hFFFF, 16'h03FF};
    tbl[2]  = '{5'h0C, 16'hFFFF, 16'h00FF};
    tbl[3]  = '{5'h04, 16'hFFFF, 16'h000F};
    tbl[4]  = '{5'h0E, 16'hBEEF, 16'hBEEF};
    tbl[5]  = '{5'h10, 16'h0055, 16'h0055};
    tbl[6]  = '{5'h14, 16'h1234, 16'hDEAD};
    tbl[7]  = '{5'h1E, 16'h5555, 16'hDEAD};
    tbl[8]  = '{5'h02, 16'hFFFF, 16'h0000};
    tbl[9]  = '{5'h00, 16'h0000, 16'h000F};
    tbl[10] = '{5'h09, 16'hABCD, 16'hABCD};
    tbl[11] = '{5'h0A, 16'h0000, 16'h0000};
    tbl[12] = '{5'h04, 16'h0000, 16'h0000};
    for (int i = 0; i < 13; i++) begin
      wr(tbl[i].off, tbl[i].wd);
      rd($sformatf("tbl[%0d]", i), tbl[i].off, tbl[i].exp);
    end

    // Output ports follow register writes.
    wr(5'h08, 16'h1234);
    wr(5'h0A, 16'h03FF);
    wr(5'h0C, 16'h00A5);
    check("hex_out", hex_out, 16'h1234);
    check("ledr", ledr, 10'h3FF);
    check("ledg", ledg, 8'hA5);
    rd("hex_rb", 5'h08, 16'h1234);
    rd("ledg_rb", 5'h0C, 16'h00A5);

    // Randomized register traffic and SW sync latency against a plain model.
    offs  = '{5'h08, 5'h0A, 5'h0C, 5'h04, 5'h0E, 5'h10};
    masks = '{16'hFFFF, 16'h03FF, 16'h00FF, 16'h000F, 16'hFFFF, 16'hFFFF};
    for (int k = 0; k < 6; k++) begin
      wr(offs[k], 16'h0000);
      m[k] = 16'h0000;
    end
    sw_old = '0; sw_new = '0; sw_cyc = cyc;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 5);
      d = 16'($urandom);
      wr(offs[r], d);
      m[r] = d & masks[r];
      if (cyc - sw_cyc >= int'(SY) && $urandom_range(0, 2) == 0) begin
        sw_old = sw_new;
        sw_new = 16'($urandom_range(0, 1023));
        sw_in  = sw_new[9:0];
        sw_cyc = cyc;
      end
      r = $urandom_range(0, 6);
      if (r == 6) rd("rnd_sw", 5'h02, (cyc - sw_cyc >= int'(SY)) ? sw_new : sw_old);
      else        rd($sformatf("rnd_reg%0h", offs[r]), offs[r], m[r]);
      check("rnd_hex_out", hex_out, m[0]);
      check("rnd_ledr", ledr, m[1][9:0]);
      check("rnd_ledg", ledg, m[2][7:0]);
      check("rnd_irq", irq, 0);
    end

    // KEY press capture, interrupt and W1C.
    wr(5'h04, 16'h0001);
    key_in = 4'b1110;
    step();
    rd("key_sync1", 5'h00, 16'h000F);
    step();
    rd("key_sync2", 5'h00, 16'h000E);
    rd("kedge_early", 5'h06, 16'h0000);
    step();
    rd("kedge_set", 5'h06, 16'h0001);
    check("irq_not_yet", irq, 0);
    step();
    check("irq_key", irq, 1);
    wr(5'h06, 16'h0001);
    rd("kedge_clr", 5'h06, 16'h0000);
    step();
    check("irq_key_clr", irq, 0);
    key_in = 4'hF;
    for (int i = 0; i < 4; i++) step();
    rd("kedge_release", 5'h06, 16'h0000);
    key_in = 4'b1101;
    step();
    step();
    wr(5'h06, 16'h0002);
    rd("kedge_set_beats_clr", 5'h06, 16'h0002);
    step();
    check("irq_masked", irq, 0);
    key_in = 4'hF;
    wr(5'h06, 16'h0002);
    rd("kedge_clr2", 5'h06, 16'h0000);

    // Timer: PRESCALE=4, TLIM=2.
    wr(5'h0E, 16'h0002);
    wr(5'h10, 16'h0000);
    wr(5'h12, 16'h0003);
    t0 = cyc;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 4)  rd("tcnt_1", 5'h10, 16'h0001);
      if (i == 8)  rd("tcnt_2", 5'h10, 16'h0002);
      if (i == 11) rd("rdy_early", 5'h12, 16'h0003);
      if (i == 12) begin
        rd("tcnt_wrap", 5'h10, 16'h0000);
        rd("rdy_set", 5'h12, 16'h0007);
        check("irq_tmr_not_yet", irq, 0);
      end
    end
    wr(5'h12, 16'h0007);
    check("irq_tmr", irq, 1);
    rd("rdy_w1c", 5'h12, 16'h0003);
    step();
    check("irq_tmr_clr", irq, 0);
    while (cyc < t0 + 23) step();
    wr(5'h12, 16'h0007);
    rd("rdy_set_beats_w1c", 5'h12, 16'h0007);
    rd("tcnt_wrap2", 5'h10, 16'h0000);

    // TCNT write on a tick edge, then TLIM=0.
    while (cyc < t0 + 27) step();
    wr(5'h10, 16'h0007);
    rd("tcnt_write_wins", 5'h10, 16'h0007);
    wr(5'h0E, 16'h0000);
    wr(5'h10, 16'h0000);
    wr(5'h12, 16'h0007);
    rd("tlim0_cleared", 5'h12, 16'h0003);
    step();
    rd("tlim0_rdy_a", 5'h12, 16'h0007);
    wr(5'h12, 16'h0007);
    step();
    step();
    rd("tlim0_gap", 5'h12, 16'h0003);
    step();
    rd("tlim0_rdy_b", 5'h12, 16'h0007);
    rd("tlim0_tcnt", 5'h10, 16'h0000);

    // Asynchronous reset mid-operation.
    wr(5'h08, 16'hBEEF);
    check("irq_before_rst", irq, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_irq", irq, 0);
    check("rst_async_hex", hex_out, 16'h0000);
    check("rst_async_ledr", ledr, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd("rst2_tctl", 5'h12, 16'h0000);
    rd("rst2_tcnt", 5'h10, 16'h0000);
    rd("rst2_tlim", 5'h0E, 16'h0000);
    step();
    rd("rst2_kedge", 5'h06, 16'h0000);
    rd("rst2_hex", 5'h08, 16'h0000);
    for (int i = 0; i < 8; i++) step();
    rd("rst2_timer_idle", 5'h10, 16'h0000);
    check("rst2_irq", irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
